// File: rtl/barrel_shift_bist.sv
// Stimulus/response engine for the 32-bit barrel shifter: LFSR vectors, bit-serial reference, compare.
// Optional macro BIST_FAIL_STOP_EN: stop on the first mismatch and freeze the failing vector.
module barrel_shift_bist #(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter int unsigned ROTATE      = 0,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [31:0]      dutNum,
  output logic [4:0]       dutAmt,
  output logic             dutLr,
  input  logic [31:0]      dutShiftedNum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] errCount,
  output logic [ERR_W-1:0] firstFailIdx,
  output logic             firstFailValid
);

  localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0]      SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [ERR_W-1:0] LAST_K    = ERR_W'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMPARE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [ERR_W-1:0] k_q, k_d;
  logic [31:0]      ref_q, ref_d;
  logic [4:0]       rem_q, rem_d;
  logic [31:0]      num_q, num_d;
  logic [4:0]       amt_q, amt_d;
  logic             lr_q, lr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [ERR_W-1:0] ffi_q, ffi_d;
  logic             ffv_q, ffv_d;

  logic [5:0]       k_lo_c;
  logic             mismatch_c;
  logic [ERR_W-1:0] err_inc_c;
  logic [ERR_W-1:0] err_next_c;
  logic             fill_c;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_INIT;
      k_q     <= '0;
      ref_q   <= '0;
      rem_q   <= '0;
      num_q   <= '0;
      amt_q   <= '0;
      lr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      k_q     <= k_d;
      ref_q   <= ref_d;
      rem_q   <= rem_d;
      num_q   <= num_d;
      amt_q   <= amt_d;
      lr_q    <= lr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    k_d     = k_q;
    ref_d   = ref_q;
    rem_d   = rem_q;
    num_d   = num_q;
    amt_d   = amt_q;
    lr_d    = lr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;

    k_lo_c     = 6'(k_q);
    mismatch_c = (dutShiftedNum != ref_q);
    err_inc_c  = (err_q == '1) ? err_q : err_q + ERR_W'(1);
    err_next_c = mismatch_c ? err_inc_c : err_q;
    fill_c     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d   = '0;
          ffi_d   = '0;
          ffv_d   = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          lfsr_d  = SEED_INIT;
          k_d     = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        num_d   = lfsr_q;
        amt_d   = k_lo_c[4:0];
        lr_d    = k_lo_c[5];
        ref_d   = lfsr_q;
        rem_d   = k_lo_c[4:0];
        state_d = (k_lo_c[4:0] == 5'd0) ? S_COMPARE : S_SHIFT;
      end

      S_SHIFT: begin
        if (lr_q) begin
          if (ROTATE != 0) fill_c = ref_q[0];
          ref_d = {fill_c, ref_q[31:1]};
        end else begin
          if (ROTATE != 0) fill_c = ref_q[31];
          ref_d = {ref_q[30:0], fill_c};
        end
        rem_d = rem_q - 5'd1;
        if (rem_q == 5'd1) state_d = S_COMPARE;
      end

      S_COMPARE: begin
        err_d = err_next_c;
        if (mismatch_c && !ffv_q) begin
          ffi_d = k_q;
          ffv_d = 1'b1;
        end
`ifdef BIST_FAIL_STOP_EN
        if (mismatch_c || (k_q == LAST_K)) begin
`else
        if (k_q == LAST_K) begin
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next_c == '0);
          state_d = S_DONE;
        end else begin
          lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
          k_d     = k_q + ERR_W'(1);
          state_d = S_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign dutNum         = num_q;
  assign dutAmt         = amt_q;
  assign dutLr          = lr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign errCount       = err_q;
  assign firstFailIdx   = ffi_q;
  assign firstFailValid = ffv_q;

endmodule
